btn_debounce: RTL
=================

# btn_debounce

Debounces and synchronises one raw mechanical push-button and turns each accepted press into a single-cycle step pulse. It sits directly upstream of the 4-bit ripple counter on the xc2v1000 board: `btn_pulse` is the count-step source for the counter stage, and `btn_level` is available for status LEDs. Repeated pulses while the button is held are an optional compile-time feature.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth, minimum 2.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a change (10 ms at 50 MHz), minimum 2.
- `REPEAT_DELAY`, 25000000: hold cycles before the first auto-repeat pulse (auto-repeat builds only).
- `REPEAT_PERIOD`, 5000000: cycles between later auto-repeat pulses (auto-repeat builds only), minimum 2.
- `CNT_W`, 25: width of the internal counters; must hold max(`DEBOUNCE_CYCLES`, `REPEAT_DELAY`, `REPEAT_PERIOD`).
- `BTN_ACTIVE_HIGH`, 1: 1 means a raw high input is "pressed"; 0 inverts the raw input.

Ports:
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: synchronous, active-low reset.
- `btn_in` input 1: raw asynchronous button pin.
- `btn_level` output 1: debounced pressed state.
- `btn_pulse` output 1: one-cycle press strobe; also carries auto-repeat strobes.
- `btn_release` output 1: one-cycle release strobe.

## Operation
- Input path: `btn_in` is polarity-normalised, then passed through a `SYNC_STAGES` flop chain to give `s`.
- FSM states:
  - IDLE: stable released.
  - PRESS_WAIT: candidate press.
  - PRESSED: stable pressed.
  - RELEASE_WAIT: candidate release.
- Transitions:
  - IDLE→PRESS_WAIT when `s`=1; the debounce counter clears to 0.
  - PRESS_WAIT: the counter increments while `s`=1. If `s`=0, return to IDLE and clear the counter. When the counter reaches `DEBOUNCE_CYCLES`-1 with `s`=1, go to PRESSED; `btn_level`←1 and `btn_pulse`←1 for one cycle.
  - PRESSED→RELEASE_WAIT when `s`=0; the counter clears.
  - RELEASE_WAIT is symmetric to PRESS_WAIT. A bounce back to `s`=1 returns to PRESSED with no strobe. On acceptance go to IDLE; `btn_level`←0 and `btn_release`←1 for one cycle.
- Every output is registered. `btn_pulse` and `btn_release` are never both high in the same cycle.
- Counters saturate and never wrap. A glitch shorter than `DEBOUNCE_CYCLES` never changes `btn_level`.
- Reset values: state IDLE; all counters 0; synchroniser flops hold the inactive value; `btn_level`=0, `btn_pulse`=0, `btn_release`=0.
- Reset mid-operation: an in-flight debounce is abandoned and no strobe is emitted. A button still held after reset is treated as a new press and produces one `btn_pulse` after the full latency.

## Timing
- Press latency: from the first `clk` edge sampling the new `btn_in` to `btn_level`/`btn_pulse` high is exactly `SYNC_STAGES`+`DEBOUNCE_CYCLES` cycles, provided the input is stable.
- Release latency: the same value, to `btn_level` low and `btn_release` high.
- Strobe width: exactly 1 cycle.
- Back-to-back events are spaced at least `DEBOUNCE_CYCLES` cycles apart.
- The reset deassertion edge counts as cycle 0 for latency.

## Configuration
- Macro: `BTN_DEBOUNCE_AUTOREPEAT_EN`.
- When defined:
  - A repeat counter runs in PRESSED. The first extra `btn_pulse` comes `REPEAT_DELAY` cycles after the initial press pulse, then one every `REPEAT_PERIOD` cycles while PRESSED.
  - Entering RELEASE_WAIT freezes the repeat counter.
  - Returning to PRESSED on a bounce resumes the repeat counter without clearing it.
  - Acceptance into IDLE clears the repeat counter.
- When undefined: the repeat logic and the `REPEAT_*` parameters are unused, and exactly one `btn_pulse` is issued per accepted press.

## Structure
- Shared header `btn_debounce_defs.vh`:
  - FSM state encodings (2-bit: IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3).
  - Default timing constants for the 50 MHz board clock.
- One sub-module, `sync_chain`: a parameterised `SYNC_STAGES` flop synchroniser with a synchronous active-low reset to a parameterised idle value. It is reused by later input blocks.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `BTN_ACTIVE_HIGH`=1.
- Clean press: `btn_in` 0→1 at cycle 0 and held → `btn_level` and `btn_pulse` high at cycle 6; `btn_pulse` low at cycle 7; `btn_level` stays 1.
- Bouncy press: pattern 1,0,1,1,0,1,1,1,1,… → no strobe until 4 consecutive synchronised 1s; then exactly one `btn_pulse`.
- Release: release after a stable press → `btn_release` high for 1 cycle exactly 6 cycles after the `btn_in` falling edge; `btn_level`=0; no `btn_pulse`.
- Glitch rejection: a 3-cycle high pulse on `btn_in` → all outputs stay 0.
- Reset mid-debounce: `reset`=0 during PRESS_WAIT with the button still held → outputs 0 during reset; after `reset`=1, `btn_pulse` arrives 6 cycles later.
- Auto-repeat (macro defined): hold for 30 cycles → `btn_pulse` at cycles 6, 16, 19, 22, 25, 28, …; with the macro undefined, only cycle 6.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared types and default timing constants for btn_debounce (50 MHz board clock).
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;     // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;   // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;    // 100 ms
    localparam int unsigned DEF_CNT_W           = 25;

endpackage

// File: rtl/btn_debounce_sync_chain.sv
// sync_chain: STAGES-deep flop synchroniser, synchronous active-low reset to IDLE_VAL.
module sync_chain #(
    parameter int unsigned STAGES   = 2,
    parameter logic        IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ff <= {STAGES{IDLE_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: synchroniser + 4-state debounce FSM with registered level/press/release strobes.
// Optional auto-repeat of btn_pulse while held: define BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned BTN_ACTIVE_HIGH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic       btn_norm;
    logic       s;
    state_e     state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic       level_d, pulse_d, release_d;

    assign btn_norm = (BTN_ACTIVE_HIGH != 0) ? btn_in : ~btn_in;

    sync_chain #(
        .STAGES   (SYNC_STAGES),
        .IDLE_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_norm),
        .q     (s)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt, rpt_d, rpt_last;
    logic             rpt_armed, rpt_armed_d;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
    assign rpt_last = rpt_armed ? RPT_NEXT : RPT_FIRST;
`else
    logic unused_repeat;
    assign unused_repeat = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        level_d   = btn_level;
        pulse_d   = 1'b0;
        release_d = 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        rpt_d       = rpt;
        rpt_armed_d = rpt_armed;
`endif
        case (state)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt == DB_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                    rpt_d       = '0;
                    rpt_armed_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else begin
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                    if (rpt == rpt_last) begin
                        pulse_d     = 1'b1;
                        rpt_d       = '0;
                        rpt_armed_d = 1'b1;
                    end else begin
                        rpt_d = (rpt == CNT_MAX) ? rpt : rpt + CNT_W'(1);
                    end
`endif
                end
            end
            ST_RELEASE_WAIT: begin
                // Bounce back keeps the repeat counter where it was frozen
                if (s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt == DB_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                    rpt_d       = '0;
                    rpt_armed_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_pulse   <= 1'b0;
            btn_release <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            rpt         <= '0;
            rpt_armed   <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            btn_level   <= level_d;
            btn_pulse   <= pulse_d;
            btn_release <= release_d;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            rpt         <= rpt_d;
            rpt_armed   <= rpt_armed_d;
`endif
        end
    end

endmodule
